// File: rtl/arbitro_memoria_dados_pkg.sv
// Shared types for the data-memory arbiter.
// FSM state encoding and requester port ids.
package pkg_memoria;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ACESSO   = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  localparam logic PORTA_CPU = 1'b0;
  localparam logic PORTA_AUX = 1'b1;

endpackage

// File: rtl/arbitro_memoria_dados_if.sv
// Requester-side bus of the data-memory arbiter.
// master: requesters (Req/We/Endereco/Dados_escrita out, Ack/Dados_leitura in).
// slave: the arbiter.
interface arbitro_memoria_dados_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);

  logic                  Req_0;
  logic                  Req_1;
  logic                  We_0;
  logic                  We_1;
  logic [ADDR_WIDTH-1:0] Endereco_0;
  logic [ADDR_WIDTH-1:0] Endereco_1;
  logic [DATA_WIDTH-1:0] Dados_escrita_0;
  logic [DATA_WIDTH-1:0] Dados_escrita_1;
  logic                  Ack_0;
  logic                  Ack_1;
  logic [DATA_WIDTH-1:0] Dados_leitura_0;
  logic [DATA_WIDTH-1:0] Dados_leitura_1;

  modport master (
    output Req_0, Req_1, We_0, We_1,
    output Endereco_0, Endereco_1,
    output Dados_escrita_0, Dados_escrita_1,
    input  Ack_0, Ack_1,
    input  Dados_leitura_0, Dados_leitura_1
  );

  modport slave (
    input  Req_0, Req_1, We_0, We_1,
    input  Endereco_0, Endereco_1,
    input  Dados_escrita_0, Dados_escrita_1,
    output Ack_0, Ack_1,
    output Dados_leitura_0, Dados_leitura_1
  );

endinterface

// File: rtl/arbitro_memoria_dados_seletor_round_robin.sv
// Combinational winner choice between the two requesters.
// Ports: req_0_i/req_1_i, ultimo_i (last served) -> vencedor_o, valido_o.
module seletor_round_robin
  import pkg_memoria::*;
#(
  parameter bit PRIORIDADE_FIXA = 1'b0
) (
  input  logic req_0_i,
  input  logic req_1_i,
  input  logic ultimo_i,
  output logic vencedor_o,
  output logic valido_o
);

  assign valido_o = req_0_i | req_1_i;

  always_comb begin
    vencedor_o = PORTA_CPU;
    unique case (1'b1)
      (req_0_i && req_1_i):
        vencedor_o = PRIORIDADE_FIXA ? PORTA_CPU : ~ultimo_i;
      (req_1_i && !req_0_i):
        vencedor_o = PORTA_AUX;
      default:
        vencedor_o = PORTA_CPU;
    endcase
  end

endmodule

// File: rtl/arbitro_memoria_dados.sv
// Arbitrates two requesters onto a registered-read data memory.
// Ports: Clock, Reset, bus (slave), Ocupado, memory enables/addresses/data.
module arbitro_memoria_dados
  import pkg_memoria::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter bit PRIORIDADE_FIXA = 1'b0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  arbitro_memoria_dados_if.slave bus,
  output logic                  Ocupado,
  output logic                  Mem_Write,
  output logic                  Mem_Read,
  output logic [ADDR_WIDTH-1:0] Endereco_escrita,
  output logic [ADDR_WIDTH-1:0] Endereco_leitura,
  output logic [DATA_WIDTH-1:0] Write_Data,
  input  logic [DATA_WIDTH-1:0] Read_Data
);

  estado_t               estado_q, estado_d;
  logic                  ultimo_q, ultimo_d;
  logic                  porta_q, porta_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] end_q, end_d;
  logic [DATA_WIDTH-1:0] dado_q, dado_d;

  logic vencedor;
  logic valido;

  seletor_round_robin #(
    .PRIORIDADE_FIXA(PRIORIDADE_FIXA)
  ) u_seletor (
    .req_0_i   (bus.Req_0),
    .req_1_i   (bus.Req_1),
    .ultimo_i  (ultimo_q),
    .vencedor_o(vencedor),
    .valido_o  (valido)
  );

  always_comb begin
    estado_d = estado_q;
    ultimo_d = ultimo_q;
    porta_d  = porta_q;
    we_d     = we_q;
    end_d    = end_q;
    dado_d   = dado_q;
    unique case (estado_q)
      OCIOSO: begin
        if (valido) begin
          estado_d = ACESSO;
          porta_d  = vencedor;
          if (vencedor == PORTA_AUX) begin
            we_d   = bus.We_1;
            end_d  = bus.Endereco_1;
            dado_d = bus.Dados_escrita_1;
          end else begin
            we_d   = bus.We_0;
            end_d  = bus.Endereco_0;
            dado_d = bus.Dados_escrita_0;
          end
        end
      end
      ACESSO: estado_d = RESPOSTA;
      RESPOSTA: begin
        estado_d = OCIOSO;
        ultimo_d = porta_q;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // Last-served starts at AUX so CPU wins the first tie.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado_q <= OCIOSO;
      ultimo_q <= PORTA_AUX;
      porta_q  <= PORTA_CPU;
      we_q     <= 1'b0;
      end_q    <= '0;
      dado_q   <= '0;
    end else begin
      estado_q <= estado_d;
      ultimo_q <= ultimo_d;
      porta_q  <= porta_d;
      we_q     <= we_d;
      end_q    <= end_d;
      dado_q   <= dado_d;
    end
  end

  // Reset gates the enables so an in-flight write never reaches memory.
  logic acesso;
  logic resposta;

  assign acesso   = (estado_q == ACESSO) && !Reset;
  assign resposta = (estado_q == RESPOSTA) && !Reset;

  assign Ocupado          = (estado_q != OCIOSO) && !Reset;
  assign Mem_Write        = acesso && we_q;
  assign Mem_Read         = acesso && !we_q;
  assign Endereco_escrita = acesso ? end_q : '0;
  assign Endereco_leitura = acesso ? end_q : '0;
  assign Write_Data       = acesso ? dado_q : '0;

  // Read_Data is the memory's registered output, valid in RESPOSTA.
  assign bus.Ack_0 = resposta && (porta_q == PORTA_CPU);
  assign bus.Ack_1 = resposta && (porta_q == PORTA_AUX);

  assign bus.Dados_leitura_0 =
    (bus.Ack_0 && !we_q) ? Read_Data : '0;
  assign bus.Dados_leitura_1 =
    (bus.Ack_1 && !we_q) ? Read_Data : '0;

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Scoreboard bench for arbitro_memoria_dados.
// Two instances: round-robin (u0) and fixed priority (u1).
module tb_arbitro_memoria_dados;

  logic clk = 1'b0;
  logic Reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= Reset ? 0 : cyc + 1;

  arbitro_memoria_dados_if if0 ();
  arbitro_memoria_dados_if if1 ();

  logic        oc0, mw0, mr0, oc1, mw1, mr1;
  logic [15:0] ea0, el0, ea1, el1;
  logic [31:0] wd0, rd0, wd1, rd1;

  arbitro_memoria_dados #(
    .PRIORIDADE_FIXA(1'b0)
  ) u0 (
    .Clock(clk), .Reset(Reset), .bus(if0),
    .Ocupado(oc0), .Mem_Write(mw0), .Mem_Read(mr0),
    .Endereco_escrita(ea0), .Endereco_leitura(el0),
    .Write_Data(wd0), .Read_Data(rd0)
  );

  arbitro_memoria_dados #(
    .PRIORIDADE_FIXA(1'b1)
  ) u1 (
    .Clock(clk), .Reset(Reset), .bus(if1),
    .Ocupado(oc1), .Mem_Write(mw1), .Mem_Read(mr1),
    .Endereco_escrita(ea1), .Endereco_leitura(el1),
    .Write_Data(wd1), .Read_Data(rd1)
  );

  logic [31:0] mem0 [0:255] = '{default: 32'h0};
  logic [31:0] mem1 [0:255] = '{default: 32'h0};

  always @(posedge clk) begin
    if (mw0) mem0[ea0[7:0]] <= wd0;
    rd0 <= mr0 ? mem0[el0[7:0]] : 32'h0;
    if (mw1) mem1[ea1[7:0]] <= wd1;
    rd1 <= mr1 ? mem1[el1[7:0]] : 32'h0;
  end

  typedef struct {
    int          u;
    int          p;
    logic [31:0] d;
    int          c;
  } ack_e;

  typedef struct {
    int          u;
    logic        we;
    logic [15:0] a;
    logic [31:0] w;
    int          c;
  } op_e;

  ack_e ackq[$];
  op_e  opq[$];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic mon(int u, int c, logic a0, logic a1,
                     logic [31:0] d0, logic [31:0] d1,
                     logic mw, logic mr,
                     logic [15:0] ea, logic [15:0] el,
                     logic [31:0] wd);
    int idx;
    logic ak;
    logic [31:0] dd;
    for (int p = 0; p < 2; p++) begin
      ak = (p == 1) ? a1 : a0;
      dd = (p == 1) ? d1 : d0;
      if (ak) begin
        idx = -1;
        foreach (ackq[i])
          if (idx < 0 && ackq[i].u == u) idx = i;
        if (idx < 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL ack_unexp u%0d p%0d: got ack at cyc %0d, expected none",
                   u, p, c);
        end else begin
          chk($sformatf("ack_port u%0d", u), p, ackq[idx].p);
          chk($sformatf("ack_data u%0d", u), dd, ackq[idx].d);
          chk($sformatf("ack_cyc u%0d", u), c, ackq[idx].c);
          ackq.delete(idx);
        end
      end else begin
        chk($sformatf("rdata_idle u%0d p%0d", u, p), dd, 0);
      end
    end
    chk($sformatf("en_excl u%0d", u), {31'h0, mw & mr}, 0);
    if (mw || mr) begin
      idx = -1;
      foreach (opq[i])
        if (idx < 0 && opq[i].u == u) idx = i;
      if (idx < 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL mem_unexp u%0d: got mw=%0d mr=%0d at cyc %0d, expected none",
                 u, mw, mr, c);
      end else begin
        chk($sformatf("mem_we u%0d", u), mw, opq[idx].we);
        chk($sformatf("mem_ea u%0d", u), ea, opq[idx].a);
        chk($sformatf("mem_el u%0d", u), el, opq[idx].a);
        chk($sformatf("mem_wd u%0d", u), wd, opq[idx].w);
        chk($sformatf("mem_cyc u%0d", u), c, opq[idx].c);
        opq.delete(idx);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, cyc, if0.Ack_0, if0.Ack_1,
        if0.Dados_leitura_0, if0.Dados_leitura_1,
        mw0, mr0, ea0, el0, wd0);
    mon(1, cyc, if1.Ack_0, if1.Ack_1,
        if1.Dados_leitura_0, if1.Dados_leitura_1,
        mw1, mr1, ea1, el1, wd1);
  end

  task automatic push(int u, int p, logic we,
                      logic [15:0] a, logic [31:0] w,
                      logic [31:0] rd, int t);
    opq.push_back('{u, we, a, w, t + 1});
    ackq.push_back('{u, p, we ? 32'h0 : rd, t + 2});
  endtask

  task automatic drive0(int p, logic r, logic we,
                        logic [15:0] a, logic [31:0] w);
    if (p == 0) begin
      if0.Req_0 = r; if0.We_0 = we;
      if0.Endereco_0 = a; if0.Dados_escrita_0 = w;
    end else begin
      if0.Req_1 = r; if0.We_1 = we;
      if0.Endereco_1 = a; if0.Dados_escrita_1 = w;
    end
  endtask

  // Single uncontended access on u0, starting in an idle cycle.
  task automatic issue(int p, logic we, logic [15:0] a,
                       logic [31:0] w, logic [31:0] rd);
    push(0, p, we, a, w, rd, cyc);
    drive0(p, 1'b1, we, a, w);
    repeat (3) @(posedge clk);
    #1;
    drive0(p, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  initial begin
    int t;
    Reset = 1'b1;
    drive0(0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive0(1, 1'b0, 1'b0, 16'h0, 32'h0);
    if1.Req_0 = 0; if1.We_0 = 0;
    if1.Endereco_0 = 0; if1.Dados_escrita_0 = 0;
    if1.Req_1 = 0; if1.We_1 = 0;
    if1.Endereco_1 = 0; if1.Dados_escrita_1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ocupado", oc0, 0);
    chk("rst_ack0", if0.Ack_0, 0);
    @(posedge clk);
    #1 Reset = 1'b0;

    issue(0, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h0);
    issue(1, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF);
    issue(1, 1'b1, 16'h0020, 32'hCAFEF00D, 32'h0);
    issue(0, 1'b0, 16'h0020, 32'h0, 32'hCAFEF00D);

    // Abort a write with Reset during ACESSO.
    drive0(0, 1'b1, 1'b1, 16'h0020, 32'h12345678);
    @(posedge clk);
    #1 Reset = 1'b1;
    @(negedge clk);
    chk("abort_mw", mw0, 0);
    chk("abort_ocupado", oc0, 0);
    @(posedge clk);
    #1 Reset = 1'b0;
    drive0(0, 1'b0, 1'b0, 16'h0, 32'h0);
    issue(0, 1'b0, 16'h0020, 32'h0, 32'hCAFEF00D);

    // Req_0 arrives during ACESSO of a port-1 write.
    t = cyc;
    push(0, 1, 1'b1, 16'h0050, 32'h11112222, 32'h0, t);
    drive0(1, 1'b1, 1'b1, 16'h0050, 32'h11112222);
    @(posedge clk);
    #1 drive0(0, 1'b1, 1'b1, 16'h0020, 32'hBAD0BAD0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 drive0(1, 1'b0, 1'b0, 16'h0, 32'h0);
    drive0(0, 1'b1, 1'b0, 16'h0050, 32'h0);
    push(0, 0, 1'b0, 16'h0050, 32'h0, 32'h11112222, t + 3);
    repeat (3) @(posedge clk);
    #1 drive0(0, 1'b0, 1'b0, 16'h0, 32'h0);

    // Both requests held from reset on both instances.
    Reset = 1'b1;
    drive0(0, 1'b1, 1'b0, 16'h0010, 32'h0);
    drive0(1, 1'b1, 1'b0, 16'h0020, 32'h0);
    if1.Req_0 = 1; if1.Endereco_0 = 16'h0040;
    if1.Req_1 = 1; if1.Endereco_1 = 16'h0044;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0)
        push(0, 0, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 3 * k);
      else
        push(0, 1, 1'b0, 16'h0020, 32'h0, 32'hCAFEF00D, 3 * k);
      push(1, 0, 1'b0, 16'h0040, 32'h0, 32'h0, 3 * k);
    end
    @(posedge clk);
    #1 Reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    drive0(0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive0(1, 1'b0, 1'b0, 16'h0, 32'h0);
    if1.Req_0 = 0;
    if1.Req_1 = 0;

    repeat (6) @(posedge clk);
    foreach (ackq[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_missing u%0d p%0d: got none, expected ack at cyc %0d",
               ackq[i].u, ackq[i].p, ackq[i].c);
    end
    foreach (opq[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL mem_missing u%0d: got none, expected access at cyc %0d",
               opq[i].u, opq[i].c);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
